// File: rtl/ats21_cmd_sched.sv
// Command scheduler for the ATS21 alarm/timer core: two lane FIFOs paired into
// one req/ctrlA/ctrlB issue, then wait for ready (or timeout) and report done.
module ats21_cmd_sched #(
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        a_valid,
  input  logic [31:0] a_instr,
  output logic        a_ready,
  input  logic        b_valid,
  input  logic [31:0] b_instr,
  output logic        b_ready,
  output logic        ats_req,
  output logic [15:0] ats_ctrlA,
  output logic [15:0] ats_ctrlB,
  input  logic        ats_ready,
  input  logic [1:0]  ats_stat,
  output logic        busy,
  output logic        done,
  output logic [1:0]  done_stat,
  output logic        done_timeout
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(TIMEOUT);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(FIFO_DEPTH);
  localparam logic [TW-1:0] TMR_LOAD = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, REQ, HI, LO, WAIT} state_t;
  state_t state, state_nxt;

  // Lane 0 is A, lane 1 is B.
  logic [31:0]   fifo_mem [2][FIFO_DEPTH];
  logic [AW-1:0] wr_ptr [2];
  logic [AW-1:0] rd_ptr [2];
  logic [AW:0]   cnt [2];
  logic [31:0]   din [2];
  logic [31:0]   head [2];
  logic [1:0]    push, pop, full, empty;

  assign din[0] = a_instr;
  assign din[1] = b_instr;

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      full[i]  = (cnt[i] == FULL_CNT);
      empty[i] = (cnt[i] == '0);
      head[i]  = fifo_mem[i][rd_ptr[i]];
    end
  end

  assign a_ready = ~full[0];
  assign b_ready = ~full[1];
  assign push    = {b_valid & ~full[1], a_valid & ~full[0]};
  assign pop     = (state == IDLE) ? ~empty : 2'b00;

  always_ff @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (push[i]) fifo_mem[i][wr_ptr[i]] <= din[i];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 2; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        cnt[i]    <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (push[i]) wr_ptr[i] <= wr_ptr[i] + 1'b1;
        if (pop[i])  rd_ptr[i] <= rd_ptr[i] + 1'b1;
        if (push[i] && !pop[i])      cnt[i] <= cnt[i] + 1'b1;
        else if (!push[i] && pop[i]) cnt[i] <= cnt[i] - 1'b1;
      end
    end
  end

  logic [31:0]   pair_a, pair_b;
  logic [TW-1:0] tmr, tmr_d;
  logic          req_d, done_d, to_d;
  logic [15:0]   ctrl_a_d, ctrl_b_d;
  logic [1:0]    stat_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Output values are computed for the state being entered, then registered.
  always_comb begin
    state_nxt = state;
    req_d     = 1'b0;
    ctrl_a_d  = 16'h0000;
    ctrl_b_d  = 16'h0000;
    done_d    = 1'b0;
    stat_d    = done_stat;
    to_d      = done_timeout;
    tmr_d     = tmr;
    case (state)
      IDLE: begin
        if (|pop) begin
          state_nxt = REQ;
          req_d     = 1'b1;
        end
      end
      REQ: begin
        state_nxt = HI;
        ctrl_a_d  = pair_a[31:16];
        ctrl_b_d  = pair_b[31:16];
      end
      HI: begin
        state_nxt = LO;
        ctrl_a_d  = pair_a[15:0];
        ctrl_b_d  = pair_b[15:0];
      end
      LO: begin
        state_nxt = WAIT;
        tmr_d     = TMR_LOAD;
      end
      WAIT: begin
        if (ats_ready) begin
          state_nxt = IDLE;
          done_d    = 1'b1;
          stat_d    = ats_stat;
          to_d      = 1'b0;
        end else if (tmr == '0) begin
          state_nxt = IDLE;
          done_d    = 1'b1;
          to_d      = 1'b1;
        end else begin
          tmr_d = tmr - 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pair_a       <= '0;
      pair_b       <= '0;
      tmr          <= '0;
      ats_req      <= 1'b0;
      ats_ctrlA    <= '0;
      ats_ctrlB    <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      done_stat    <= '0;
      done_timeout <= 1'b0;
    end else begin
      if (|pop) begin
        pair_a <= empty[0] ? 32'h0000_0000 : head[0];
        pair_b <= empty[1] ? 32'h0000_0000 : head[1];
      end
      tmr          <= tmr_d;
      ats_req      <= req_d;
      ats_ctrlA    <= ctrl_a_d;
      ats_ctrlB    <= ctrl_b_d;
      busy         <= (state_nxt != IDLE);
      done         <= done_d;
      done_stat    <= stat_d;
      done_timeout <= to_d;
    end
  end

endmodule

// File: tb/tb_ats21_cmd_sched.sv
// Directed bench for ats21_cmd_sched: single/paired issue, backpressure,
// timeout, ready/timeout collision and asynchronous reset mid-issue.
module tb_ats21_cmd_sched;
  localparam int FIFO_DEPTH = 4;
  localparam int TIMEOUT    = 12;

  logic        clk = 1'b0;
  logic        reset, a_valid, b_valid, ats_ready;
  logic [31:0] a_instr, b_instr;
  logic [1:0]  ats_stat;
  logic        a_ready, b_ready, ats_req, busy, done, done_timeout;
  logic [15:0] ats_ctrlA, ats_ctrlB;
  logic [1:0]  done_stat;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [31:0] bp_vals [6] = '{32'hA100_B100, 32'hA200_B200, 32'hA300_B300,
                               32'hA400_B400, 32'hA500_B500, 32'hA600_B600};

  ats21_cmd_sched #(.FIFO_DEPTH(FIFO_DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .a_valid(a_valid), .a_instr(a_instr), .a_ready(a_ready),
    .b_valid(b_valid), .b_instr(b_instr), .b_ready(b_ready),
    .ats_req(ats_req), .ats_ctrlA(ats_ctrlA), .ats_ctrlB(ats_ctrlB),
    .ats_ready(ats_ready), .ats_stat(ats_stat),
    .busy(busy), .done(done), .done_stat(done_stat), .done_timeout(done_timeout)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want $finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req(input int budget, output bit got);
    got = 1'b0;
    for (int c = 0; c < budget && !got; c++) begin
      if (ats_req === 1'b1) got = 1'b1;
      else tick();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; a_valid = 1'b0; b_valid = 1'b0; a_instr = '0; b_instr = '0;
    ats_ready = 1'b0; ats_stat = 2'b00;
    #12;
    tests_run++;
    if ({ats_req, busy, done, done_timeout} !== 4'b0000) begin
      tests_failed++;
      $display("FAIL reset_flags: got req/busy/done/to=%b want 0000", {ats_req, busy, done, done_timeout});
    end
    tests_run++;
    if ({ats_ctrlA, ats_ctrlB, done_stat} !== 34'h0) begin
      tests_failed++;
      $display("FAIL reset_words: got ctrlA=%h ctrlB=%h stat=%b want 0", ats_ctrlA, ats_ctrlB, done_stat);
    end
    tests_run++;
    if ({a_ready, b_ready} !== 2'b11) begin
      tests_failed++;
      $display("FAIL reset_ready: got %b want 11", {a_ready, b_ready});
    end
    tick();
    reset = 1'b0;
    tick(); tick();
    tests_run++;
    if ({ats_req, busy} !== 2'b00) begin
      tests_failed++;
      $display("FAIL reset_idle: got req/busy=%b want 00", {ats_req, busy});
    end
  endtask

  task automatic test_single_lane();
    a_valid = 1'b1; a_instr = 32'h2200_0000;
    tick();
    a_valid = 1'b0;
    tests_run++;
    if ({ats_req, busy} !== 2'b00) begin
      tests_failed++;
      $display("FAIL single_no_bypass: got req/busy=%b want 00", {ats_req, busy});
    end
    tick();
    tests_run++;
    if ({ats_req, busy, ats_ctrlA, ats_ctrlB} !== {2'b11, 32'h0}) begin
      tests_failed++;
      $display("FAIL single_req: got req=%b busy=%b ctrl=%h/%h want 1 1 0000/0000", ats_req, busy, ats_ctrlA, ats_ctrlB);
    end
    tick();
    tests_run++;
    if ({ats_req, ats_ctrlA, ats_ctrlB} !== {1'b0, 16'h2200, 16'h0000}) begin
      tests_failed++;
      $display("FAIL single_hi: got req=%b ctrl=%h/%h want 0 2200/0000", ats_req, ats_ctrlA, ats_ctrlB);
    end
    tick();
    tests_run++;
    if ({ats_ctrlA, ats_ctrlB} !== 32'h0) begin
      tests_failed++;
      $display("FAIL single_lo: got ctrl=%h/%h want 0000/0000", ats_ctrlA, ats_ctrlB);
    end
    tick(); tick(); tick();
    tests_run++;
    if ({done, busy} !== 2'b01) begin
      tests_failed++;
      $display("FAIL single_waiting: got done/busy=%b want 01", {done, busy});
    end
    ats_ready = 1'b1; ats_stat = 2'b01;
    tick();
    ats_ready = 1'b0; ats_stat = 2'b00;
    tests_run++;
    if ({done, done_stat, done_timeout, busy} !== 5'b1_01_0_0) begin
      tests_failed++;
      $display("FAIL single_done: got done=%b stat=%b to=%b busy=%b want 1 01 0 0", done, done_stat, done_timeout, busy);
    end
    tick();
    tests_run++;
    if ({done, done_stat} !== 3'b0_01) begin
      tests_failed++;
      $display("FAIL single_pulse: got done=%b stat=%b want 0 01", done, done_stat);
    end
  endtask

  task automatic test_paired();
    bit seen;
    a_valid = 1'b1; a_instr = 32'h1111_4444;
    b_valid = 1'b1; b_instr = 32'h2222_3333;
    tick();
    a_valid = 1'b0; b_valid = 1'b0;
    tick();
    tests_run++;
    if (ats_req !== 1'b1) begin
      tests_failed++;
      $display("FAIL paired_req: got %b want 1", ats_req);
    end
    tick();
    tests_run++;
    if ({ats_req, ats_ctrlA, ats_ctrlB} !== {1'b0, 16'h1111, 16'h2222}) begin
      tests_failed++;
      $display("FAIL paired_hi: got req=%b ctrl=%h/%h want 0 1111/2222", ats_req, ats_ctrlA, ats_ctrlB);
    end
    tick();
    tests_run++;
    if ({ats_ctrlA, ats_ctrlB} !== {16'h4444, 16'h3333}) begin
      tests_failed++;
      $display("FAIL paired_lo: got ctrl=%h/%h want 4444/3333", ats_ctrlA, ats_ctrlB);
    end
    tick();
    ats_ready = 1'b1; ats_stat = 2'b10;
    tick();
    ats_ready = 1'b0;
    tests_run++;
    if ({done, done_stat, done_timeout} !== 4'b1_10_0) begin
      tests_failed++;
      $display("FAIL paired_done: got done=%b stat=%b to=%b want 1 10 0", done, done_stat, done_timeout);
    end
    seen = 1'b0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (ats_req === 1'b1) seen = 1'b1;
    end
    tests_run++;
    if (seen !== 1'b0) begin
      tests_failed++;
      $display("FAIL paired_empty: got extra req=%b want 0", seen);
    end
  endtask

  task automatic test_back_to_back();
    bit got, seen;
    logic [31:0] v;
    ats_ready = 1'b0;
    a_valid = 1'b1; a_instr = bp_vals[0];
    tick();
    a_instr = bp_vals[1];
    tick();
    tests_run++;
    if (ats_req !== 1'b1) begin
      tests_failed++;
      $display("FAIL bp_first_req: got %b want 1", ats_req);
    end
    a_instr = bp_vals[2];
    tick();
    v = bp_vals[0];
    tests_run++;
    if (ats_ctrlA !== v[31:16]) begin
      tests_failed++;
      $display("FAIL bp_first_hi: got %h want %h", ats_ctrlA, v[31:16]);
    end
    a_instr = bp_vals[3];
    tick();
    a_instr = bp_vals[4];
    tests_run++;
    if (a_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL bp_ready_before_full: got %b want 1", a_ready);
    end
    tick();
    tests_run++;
    if (a_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL bp_full: got a_ready=%b want 0", a_ready);
    end
    a_instr = bp_vals[5];
    tick();
    a_valid = 1'b0;
    tests_run++;
    if (a_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL bp_still_full: got a_ready=%b want 0", a_ready);
    end
    ats_ready = 1'b1; ats_stat = 2'b00;
    tick();
    ats_ready = 1'b0;
    tests_run++;
    if ({done, done_timeout} !== 2'b10) begin
      tests_failed++;
      $display("FAIL bp_first_done: got done/to=%b want 10", {done, done_timeout});
    end
    for (int k = 1; k < 5; k++) begin
      v = bp_vals[k];
      wait_req(8, got);
      tests_run++;
      if (got !== 1'b1) begin
        tests_failed++;
        $display("FAIL bp_req_%0d: got no req want req within 8 cycles", k);
      end
      tick();
      tests_run++;
      if ({ats_ctrlA, ats_ctrlB} !== {v[31:16], 16'h0000}) begin
        tests_failed++;
        $display("FAIL bp_hi_%0d: got %h/%h want %h/0000", k, ats_ctrlA, ats_ctrlB, v[31:16]);
      end
      tick();
      tests_run++;
      if (ats_ctrlA !== v[15:0]) begin
        tests_failed++;
        $display("FAIL bp_lo_%0d: got %h want %h", k, ats_ctrlA, v[15:0]);
      end
      tick();
      ats_ready = 1'b1; ats_stat = (k == 4) ? 2'b11 : 2'b00;
      tick();
      ats_ready = 1'b0;
      tests_run++;
      if (done !== 1'b1) begin
        tests_failed++;
        $display("FAIL bp_done_%0d: got %b want 1", k, done);
      end
    end
    seen = 1'b0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (ats_req === 1'b1) seen = 1'b1;
    end
    tests_run++;
    if (seen !== 1'b0) begin
      tests_failed++;
      $display("FAIL bp_rejected_push: got extra req=%b want 0", seen);
    end
  endtask

  task automatic test_timeout();
    bit early;
    ats_ready = 1'b0;
    a_valid = 1'b1; a_instr = 32'hC1C2_C3C4;
    b_valid = 1'b1; b_instr = 32'hD1D2_D3D4;
    tick();
    b_valid = 1'b0; a_instr = 32'hE1E2_E3E4;
    tick();
    a_valid = 1'b0;
    tick();
    tests_run++;
    if ({ats_ctrlA, ats_ctrlB} !== {16'hC1C2, 16'hD1D2}) begin
      tests_failed++;
      $display("FAIL to_hi: got %h/%h want c1c2/d1d2", ats_ctrlA, ats_ctrlB);
    end
    tick();
    tick();
    early = 1'b0;
    for (int c = 1; c < TIMEOUT; c++) begin
      tick();
      if (done !== 1'b0) early = 1'b1;
    end
    tests_run++;
    if (early !== 1'b0) begin
      tests_failed++;
      $display("FAIL to_early: got early done=%b want 0", early);
    end
    tick();
    tests_run++;
    if ({done, done_timeout, done_stat, busy} !== 5'b1_1_11_0) begin
      tests_failed++;
      $display("FAIL to_done: got done=%b to=%b stat=%b busy=%b want 1 1 11 0", done, done_timeout, done_stat, busy);
    end
    tick();
    tests_run++;
    if (ats_req !== 1'b1) begin
      tests_failed++;
      $display("FAIL to_next_req: got %b want 1", ats_req);
    end
    tick();
    tests_run++;
    if ({ats_ctrlA, ats_ctrlB} !== {16'hE1E2, 16'h0000}) begin
      tests_failed++;
      $display("FAIL to_next_hi: got %h/%h want e1e2/0000", ats_ctrlA, ats_ctrlB);
    end
    tick();
    tick();
    ats_ready = 1'b1; ats_stat = 2'b01;
    tick();
    ats_ready = 1'b0;
    tests_run++;
    if ({done, done_timeout, done_stat} !== 4'b1_0_01) begin
      tests_failed++;
      $display("FAIL to_next_done: got done=%b to=%b stat=%b want 1 0 01", done, done_timeout, done_stat);
    end
    tick();
  endtask

  task automatic test_simultaneous();
    a_valid = 1'b1; a_instr = 32'h0F0F_F0F0;
    tick();
    a_valid = 1'b0;
    tick(); tick(); tick(); tick();
    for (int c = 1; c < TIMEOUT; c++) tick();
    ats_ready = 1'b1; ats_stat = 2'b10;
    tick();
    ats_ready = 1'b0;
    tests_run++;
    if ({done, done_timeout, done_stat} !== 4'b1_0_10) begin
      tests_failed++;
      $display("FAIL simul_done: got done=%b to=%b stat=%b want 1 0 10", done, done_timeout, done_stat);
    end
    tick();
    tests_run++;
    if ({done, busy} !== 2'b00) begin
      tests_failed++;
      $display("FAIL simul_after: got done/busy=%b want 00", {done, busy});
    end
  endtask

  task automatic test_reset_mid();
    bit seen;
    a_valid = 1'b1; a_instr = 32'h5555_6666;
    b_valid = 1'b1; b_instr = 32'h7777_8888;
    tick();
    b_valid = 1'b0; a_instr = 32'h9999_AAAA;
    tick();
    a_valid = 1'b0;
    tick();
    tests_run++;
    if (ats_ctrlA !== 16'h5555) begin
      tests_failed++;
      $display("FAIL rst_mid_hi: got %h want 5555", ats_ctrlA);
    end
    reset = 1'b1;
    #1;
    tests_run++;
    if ({ats_req, busy, done, done_timeout, done_stat, ats_ctrlA, ats_ctrlB} !== 38'h0) begin
      tests_failed++;
      $display("FAIL rst_mid_async: got req=%b busy=%b done=%b to=%b stat=%b ctrl=%h/%h want all 0",
               ats_req, busy, done, done_timeout, done_stat, ats_ctrlA, ats_ctrlB);
    end
    tick();
    reset = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (ats_req === 1'b1 || busy === 1'b1) seen = 1'b1;
    end
    tests_run++;
    if (seen !== 1'b0) begin
      tests_failed++;
      $display("FAIL rst_mid_quiet: got activity=%b want 0", seen);
    end
    tests_run++;
    if ({a_ready, b_ready} !== 2'b11) begin
      tests_failed++;
      $display("FAIL rst_mid_ready: got %b want 11", {a_ready, b_ready});
    end
  endtask

  initial begin
    test_reset();
    test_single_lane();
    test_paired();
    test_back_to_back();
    test_timeout();
    test_simultaneous();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
